// File: rtl/pulse_window_meter_pkg.sv
// pulse_window_meter_pkg: FSM encodings and saturating-increment helper
package pulse_window_meter_pkg;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    function automatic logic [31:0] sat_inc(input logic [31:0] a, input logic [31:0] max, input logic b);
        return (b && a != max) ? a + 32'd1 : a;
    endfunction
endpackage

// File: rtl/pulse_window_meter_edge_rise.sv
// edge_rise: registered rising-edge detector
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic d_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) d_q <= 1'b0;
        else d_q <= d;
    assign rise = d & ~d_q;
endmodule

// File: rtl/pulse_window_meter.sv
// pulse_window_meter: counts input pulse rises per fixed window, result on valid/ready
module pulse_window_meter
    import pulse_window_meter_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int WIN_W  = 8,
    parameter int WINDOW = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_p,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    input  logic             ready,
    output logic             overrun,
    output logic             busy
);
    localparam logic [WIN_W-1:0] last    = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] acc_max = {CNT_W{1'b1}};
    state_t           state;
    logic [WIN_W-1:0] win;
    logic [CNT_W-1:0] acc, nxt;
    logic             rise, close, cont;
    edge_rise u_edge (.clk(clk), .rst(rst), .d(in_p), .rise(rise));
    assign nxt   = CNT_W'(sat_inc(32'(acc), 32'(acc_max), rise));
    assign close = state == RUN && en && win == last;
    assign cont  = en && !close;
    assign busy  = state == RUN;
    // idle keeps win/acc at zero, so entry from IDLE naturally becomes window cycle 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            win     <= '0;
            acc     <= '0;
            count   <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= en ? RUN : IDLE;
            win   <= cont ? win + 1'b1 : '0;
            acc   <= cont ? nxt : '0;
            if (close && (!valid || ready)) begin
                count <= nxt;
                valid <= 1'b1;
            end else if (close) overrun <= 1'b1;
            else if (valid && ready) valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pulse_window_meter.sv
// tb_pulse_window_meter: directed checks of window counting, handshake, saturation, abort and reset
module tb_pulse_window_meter;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, in_p = 1'b0, ready = 1'b1;
    logic [7:0] count;
    logic [1:0] count_s;
    logic valid, overrun, busy, valid_s, overrun_s, busy_s;
    int n_cmp = 0, n_err = 0;

    pulse_window_meter #(.CNT_W(8), .WIN_W(8), .WINDOW(10)) dut (
        .clk(clk), .rst(rst), .en(en), .in_p(in_p), .count(count), .valid(valid),
        .ready(ready), .overrun(overrun), .busy(busy));
    pulse_window_meter #(.CNT_W(2), .WIN_W(8), .WINDOW(10)) dut_s (
        .clk(clk), .rst(rst), .en(en), .in_p(in_p), .count(count_s), .valid(valid_s),
        .ready(ready), .overrun(overrun_s), .busy(busy_s));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_window(input logic [9:0] pat);
        for (int c = 0; c < 10; c++) begin
            in_p = pat[c];
            step();
        end
        in_p = 1'b0;
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic stop_and_drain(input string name);
        en = 1'b0;
        ready = 1'b1;
        step();
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_drain got valid=%b busy=%b want 0 0", name, valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_cmp++;
        if ({count, valid, overrun, busy} !== 11'd0) begin
            n_err++;
            $display("FAIL reset got count=%0d valid=%b overrun=%b busy=%b want all 0", count, valid, overrun, busy);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        en = 1'b1;
        ready = 1'b1;
        step();
        n_cmp++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_start got busy=%b valid=%b want 1 0", busy, valid);
        end
        en = 1'b0;
        step();
        en = 1'b1;
        run_window(10'b0010010010);
        n_cmp++;
        if (valid !== 1'b1 || count !== 8'd3) begin
            n_err++;
            $display("FAIL basic_close got valid=%b count=%0d want 1 3", valid, count);
        end
        stop_and_drain("basic");
    endtask

    task automatic test_held_level();
        en = 1'b1;
        run_window(10'b1111111111);
        n_cmp++;
        if (valid !== 1'b1 || count !== 8'd1) begin
            n_err++;
            $display("FAIL held_close got valid=%b count=%0d want 1 1", valid, count);
        end
        stop_and_drain("held");
    endtask

    task automatic test_saturation();
        en = 1'b1;
        run_window(10'b0101010101);
        n_cmp++;
        if (valid_s !== 1'b1 || count_s !== 2'd3 || overrun_s !== 1'b0) begin
            n_err++;
            $display("FAIL sat_close got valid=%b count=%0d overrun=%b want 1 3 0", valid_s, count_s, overrun_s);
        end
        chk("sat_wide_count", int'(count), 5);
        stop_and_drain("sat");
    endtask

    task automatic test_overrun();
        en = 1'b1;
        ready = 1'b0;
        run_window(10'b0000001001);
        n_cmp++;
        if (valid !== 1'b1 || count !== 8'd2 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_first got valid=%b count=%0d overrun=%b want 1 2 0", valid, count, overrun);
        end
        run_window(10'b0101010101);
        n_cmp++;
        if (valid !== 1'b1 || count !== 8'd2 || overrun !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_second got valid=%b count=%0d overrun=%b want 1 2 1", valid, count, overrun);
        end
        stop_and_drain("ovr");
        chk("ovr_sticky", int'(overrun), 1);
    endtask

    task automatic test_close_accept();
        test_reset();
        en = 1'b1;
        ready = 1'b0;
        run_window(10'b0000001001);
        chk("acc_first_count", int'(count), 2);
        for (int c = 0; c < 10; c++) begin
            in_p = (c % 3 == 0);
            ready = (c == 9);
            step();
        end
        in_p = 1'b0;
        n_cmp++;
        if (valid !== 1'b1 || count !== 8'd4 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL acc_close got valid=%b count=%0d overrun=%b want 1 4 0", valid, count, overrun);
        end
        stop_and_drain("acc");
    endtask

    task automatic test_abort();
        en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_p = c[0];
            step();
        end
        chk("abort_busy_before", int'(busy), 1);
        en = 1'b0;
        in_p = 1'b0;
        step();
        chk("abort_busy_after", int'(busy), 0);
        for (int c = 0; c < 10; c++) step();
        chk("abort_no_valid", int'(valid), 0);
        chk("abort_no_overrun", int'(overrun), 0);
    endtask

    task automatic test_reset_mid();
        en = 1'b1;
        ready = 1'b0;
        run_window(10'b0000000101);
        run_window(10'b0000000101);
        chk("rmid_setup_overrun", int'(overrun), 1);
        run_window(10'b0000000001);
        for (int c = 0; c < 3; c++) begin
            in_p = ~in_p;
            step();
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({count, valid, overrun, busy} !== 11'd0) begin
            n_err++;
            $display("FAIL rmid_async got count=%0d valid=%b overrun=%b busy=%b want all 0", count, valid, overrun, busy);
        end
        step();
        rst = 1'b0;
        en = 1'b0;
        in_p = 1'b0;
        step();
        chk("rmid_idle_busy", int'(busy), 0);
        en = 1'b1;
        ready = 1'b1;
        run_window(10'b1000000001);
        chk("rmid_fresh_count", int'(count), 2);
        chk("rmid_fresh_valid", int'(valid), 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_held_level();
        test_saturation();
        test_overrun();
        test_close_accept();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
